// File: rtl/legv8_pkg.sv
// ----------------------------------------------------------------------------
// legv8_pkg
// Shared constants and types for the LEGv8 instruction-fetch slice.
//   PC_W / INSTR_W   : program-counter and instruction-word widths
//   OPC_MSB/OPC_LSB  : opcode field position inside an instruction word
//   HALT_WORD        : instruction word that stops fetch when the optional
//                      halt feature (INSTR_FETCH_HALT_EN) is compiled in
//   fetch_state_e    : fetch sequencer states
// Configuration macro: INSTR_FETCH_HALT_EN (adds the HALT state).
// ----------------------------------------------------------------------------
package legv8_pkg;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 21;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_BUBBLE = 2'd2
`ifdef INSTR_FETCH_HALT_EN
        , ST_HALT = 2'd3
`endif
    } fetch_state_e;

endpackage

// File: rtl/instr_mem.sv
// ----------------------------------------------------------------------------
// instr_mem
// Word-addressed instruction store: one write port, one synchronous read
// port whose output register is the fetched instruction.
//   clk_i        : clock
//   rst_i        : synchronous active-high reset (read register only)
//   rd_en_i      : capture mem[rd_idx_i] into the read register
//   rd_idx_i     : read word index
//   rd_data_o    : registered read word
//   wr_en_i      : write strobe
//   wr_idx_i     : write word index
//   wr_data_i    : write word
//   rd_is_halt_o : (INSTR_FETCH_HALT_EN only) word at rd_idx_i is HALT_WORD
// ----------------------------------------------------------------------------
module instr_mem
    import legv8_pkg::*;
#(
    parameter int IMEM_DEPTH = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rd_en_i,
    input  logic [$clog2(IMEM_DEPTH)-1:0] rd_idx_i,
    output logic [INSTR_W-1:0]            rd_data_o,
    input  logic                          wr_en_i,
    input  logic [$clog2(IMEM_DEPTH)-1:0] wr_idx_i,
    input  logic [INSTR_W-1:0]            wr_data_i
`ifdef INSTR_FETCH_HALT_EN
    ,
    output logic                          rd_is_halt_o
`endif
);

    logic [INSTR_W-1:0] mem_q [IMEM_DEPTH];
    logic [INSTR_W-1:0] rd_data_q;

    // NOTE: the array has no reset so it maps onto RAM and keeps its program
    // across a reset; only the read register is cleared.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // NOTE: non-blocking updates mean a same-edge write is not yet visible
    // here, which gives read-before-write on an index collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

`ifdef INSTR_FETCH_HALT_EN
    // Look-ahead at the word about to be fetched so the halt decision is
    // made on the same edge that would otherwise present it.
    assign rd_is_halt_o = (mem_q[rd_idx_i] == HALT_WORD);
`endif

endmodule

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
// Instruction-fetch stage: sequential PC, one-bubble taken-branch redirect,
// stall hold, loadable instruction memory.
//   CLK, RESET     : clock, synchronous active-high reset
//   STALL          : downstream not ready; hold PC and all outputs
//   BRANCH_TAKEN   : redirect request; BRANCH_OFFSET is a signed word offset
//                    from PC_OUT
//   LOAD_EN/ADDR/DATA : instruction-memory write (byte address, [1:0] ignored)
//   PC_OUT, INSTR_OUT, OPCODE_OUT, INSTR_VALID : fetched instruction
//   HALTED         : fetch stopped on HALT_WORD (tied 0 without the macro)
// Configuration macro: INSTR_FETCH_HALT_EN enables the halt-word stop.
// ----------------------------------------------------------------------------
module instr_fetch
    import legv8_pkg::*;
#(
    parameter int              IMEM_DEPTH = 64,
    parameter logic [PC_W-1:0] RESET_PC   = 64'h0
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               STALL,
    input  logic               BRANCH_TAKEN,
    input  logic [PC_W-1:0]    BRANCH_OFFSET,
    input  logic               LOAD_EN,
    input  logic [PC_W-1:0]    LOAD_ADDR,
    input  logic [INSTR_W-1:0] LOAD_DATA,
    output logic [PC_W-1:0]    PC_OUT,
    output logic [INSTR_W-1:0] INSTR_OUT,
    output logic [OPC_W-1:0]   OPCODE_OUT,
    output logic               INSTR_VALID,
    output logic               HALTED
);

    localparam int IDX_W = $clog2(IMEM_DEPTH);

    fetch_state_e       state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_out_q;
    logic               valid_q;
    logic [INSTR_W-1:0] instr_word;

    logic take_branch;
    logic do_fetch;
    logic halt_hit;
    logic rd_en;

    // A redirect is only accepted against a live instruction, which also
    // rules out BUBBLE (valid is low there).
    assign take_branch = (state_q == ST_FETCH) && !STALL && BRANCH_TAKEN && valid_q;

    // BUBBLE's closing edge is itself the fetch at the redirected PC.
    assign do_fetch = !STALL &&
                      (((state_q == ST_FETCH) && !take_branch) || (state_q == ST_BUBBLE));

`ifdef INSTR_FETCH_HALT_EN
    logic word_is_halt;
    logic halted_q;
    assign halt_hit = do_fetch && word_is_halt;
    assign HALTED   = halted_q;
`else
    assign halt_hit = 1'b0;
    assign HALTED   = 1'b0;
`endif

    // A halt word is never captured, so INSTR_OUT keeps the last live word.
    assign rd_en = do_fetch && !halt_hit;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
`ifdef INSTR_FETCH_HALT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_FETCH;
                end
                ST_FETCH, ST_BUBBLE: begin
                    if (take_branch) begin
                        pc_q    <= pc_out_q + (BRANCH_OFFSET << 2);
                        valid_q <= 1'b0;
                        state_q <= ST_BUBBLE;
`ifdef INSTR_FETCH_HALT_EN
                    end else if (halt_hit) begin
                        valid_q  <= 1'b0;
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
`endif
                    end else if (do_fetch) begin
                        pc_out_q <= pc_q;
                        valid_q  <= 1'b1;
                        pc_q     <= pc_q + PC_W'(4);
                        state_q  <= ST_FETCH;
                    end
                end
`ifdef INSTR_FETCH_HALT_EN
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    instr_mem #(
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_mem (
        .clk_i        (CLK),
        .rst_i        (RESET),
        .rd_en_i      (rd_en),
        .rd_idx_i     (pc_q[IDX_W+1:2]),
        .rd_data_o    (instr_word),
        .wr_en_i      (LOAD_EN),
        .wr_idx_i     (LOAD_ADDR[IDX_W+1:2]),
        .wr_data_i    (LOAD_DATA)
`ifdef INSTR_FETCH_HALT_EN
        ,
        .rd_is_halt_o (word_is_halt)
`endif
    );

    // Load address bits outside the word index are don't-care.
    logic unused_load_addr;
    assign unused_load_addr = ^{LOAD_ADDR[PC_W-1:IDX_W+2], LOAD_ADDR[1:0]};

    assign PC_OUT      = pc_out_q;
    assign INSTR_OUT   = instr_word;
    assign OPCODE_OUT  = instr_word[OPC_MSB:OPC_LSB];
    assign INSTR_VALID = valid_q;

endmodule
